// File: rtl/seg_pkg.sv
// Shared constants for the six-digit 7-segment scan driver: active-low glyphs,
// blink-select encodings, digit indices and the scan state type.
package seg_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] BLINK_NONE = 2'b00;
    localparam logic [1:0] BLINK_SEC  = 2'b01;
    localparam logic [1:0] BLINK_MIN  = 2'b10;
    localparam logic [1:0] BLINK_HR   = 2'b11;

    localparam int NUM_DIGITS = 6;

    localparam logic [2:0] DIG_SEC_U = 3'd0;
    localparam logic [2:0] DIG_SEC_T = 3'd1;
    localparam logic [2:0] DIG_MIN_U = 3'd2;
    localparam logic [2:0] DIG_MIN_T = 3'd3;
    localparam logic [2:0] DIG_HR_U  = 3'd4;
    localparam logic [2:0] DIG_HR_T  = 3'd5;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_DEAD  = 1'b1
    } scan_state_t;

    // Blink code that selects the field containing digit idx (0,1->SEC; 2,3->MIN; 4,5->HR).
    function automatic logic [1:0] digit_field(input logic [2:0] idx);
        return idx[2:1] + 2'd1;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-low 7-segment glyph {g,f,e,d,c,b,a}; values above 9 are blank.
module bcd_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver with frame snapshot, dead time and field blink.
// Define SEG_LEADING_ZERO_BLANK_EN to blank a leading zero in the hours-tens digit.
//   state    | meaning
//   ST_DRIVE | selected column low, segments carry the decoded digit
//   ST_DEAD  | last count of the slot, all columns and segments off
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int         SCAN_DIV   = 32,
    parameter int         BLINK_HALF = 16384,
    parameter logic [5:0] DP_MASK    = 6'b010100
) (
    input  logic        clk_32_768K,
    input  logic        rst_n,
    input  logic [23:0] Number_Data,
    input  logic [1:0]  Blink,
    output logic [7:0]  Row_Scan_Sig,
    output logic [5:0]  Column_Scan_Sig
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [SCAN_W-1:0]  SLOT_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  DRIVE_LAST = SCAN_W'(SCAN_DIV - 2);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [SCAN_W-1:0]  slot_cnt_q,  slot_cnt_d;
    logic [2:0]         digit_idx_q, digit_idx_d;
    logic [23:0]        snap_q,      snap_d;
    scan_state_t        state_q,     state_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_dark_q, blink_dark_d;
    logic [1:0]         blink_prev_q, blink_prev_d;
    logic [7:0]         row_q,       row_d;
    logic [5:0]         col_q,       col_d;

    logic       slot_wrap;
    logic       blink_changed;
    logic       field_dark;
    logic [3:0] nibble;
    logic [6:0] seg7_n;
    logic [6:0] seg_bits;

    bcd_to_seg7 u_bcd_to_seg7 (
        .bcd   (nibble),
        .seg_n (seg7_n)
    );

    always_comb begin
        slot_wrap   = (slot_cnt_q == SLOT_LAST);
        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        snap_d      = snap_q;
        if (slot_wrap) begin
            if (digit_idx_q == DIG_HR_T) begin
                digit_idx_d = DIG_SEC_U;
                snap_d      = Number_Data;
            end else begin
                digit_idx_d = digit_idx_q + 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DRIVE: if (slot_cnt_q == DRIVE_LAST) state_d = ST_DEAD;
            ST_DEAD:  state_d = ST_DRIVE;
            default:  state_d = ST_DRIVE;
        endcase
    end

    always_comb begin
        blink_prev_d  = Blink;
        blink_changed = (Blink != blink_prev_q);
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_dark_d  = blink_dark_q;
        if (blink_changed) begin
            blink_cnt_d  = '0;
            blink_dark_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d  = '0;
            blink_dark_d = ~blink_dark_q;
        end
    end

    always_comb begin
        nibble = 4'h0;
        case (digit_idx_q)
            DIG_SEC_U: nibble = snap_q[3:0];
            DIG_SEC_T: nibble = snap_q[7:4];
            DIG_MIN_U: nibble = snap_q[11:8];
            DIG_MIN_T: nibble = snap_q[15:12];
            DIG_HR_U:  nibble = snap_q[19:16];
            DIG_HR_T:  nibble = snap_q[23:20];
            default:   nibble = 4'h0;
        endcase
    end

    always_comb begin
        seg_bits = seg7_n;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (digit_idx_q == DIG_HR_T && nibble == 4'd0) seg_bits = SEG_BLANK;
`endif
        // A fresh Blink selection is shown at once, even if the old phase was dark.
        field_dark = blink_dark_q && !blink_changed && (Blink != BLINK_NONE)
                     && (Blink == digit_field(digit_idx_q));
        row_d = 8'hFF;
        col_d = 6'h3F;
        if (state_q == ST_DRIVE) begin
            col_d = ~(6'b000001 << digit_idx_q);
            row_d = field_dark ? 8'hFF : {~DP_MASK[digit_idx_q], seg_bits};
        end
    end

    always_ff @(posedge clk_32_768K or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q   <= '0;
            digit_idx_q  <= DIG_SEC_U;
            snap_q       <= 24'h0;
            state_q      <= ST_DRIVE;
            blink_cnt_q  <= '0;
            blink_dark_q <= 1'b0;
            blink_prev_q <= BLINK_NONE;
            row_q        <= 8'hFF;
            col_q        <= 6'h3F;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_idx_q  <= digit_idx_d;
            snap_q       <= snap_d;
            state_q      <= state_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_dark_q <= blink_dark_d;
            blink_prev_q <= blink_prev_d;
            row_q        <= row_d;
            col_q        <= col_d;
        end
    end

    assign Row_Scan_Sig    = row_q;
    assign Column_Scan_Sig = col_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a cycle model pushes expected outputs, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_seg_scan_driver;

    localparam int         SCAN_DIV   = 32;
    localparam int         BLINK_HALF = 16384;
    localparam logic [5:0] DP_MASK    = 6'b010100;
    localparam int         FRAME      = 6 * SCAN_DIV;

    logic        clk_32_768K = 1'b0;
    logic        rst_n       = 1'b1;
    logic [23:0] Number_Data = 24'h0;
    logic [1:0]  Blink       = 2'b00;
    logic [7:0]  Row_Scan_Sig;
    logic [5:0]  Column_Scan_Sig;

    seg_scan_driver #(
        .SCAN_DIV   (SCAN_DIV),
        .BLINK_HALF (BLINK_HALF),
        .DP_MASK    (DP_MASK)
    ) dut (
        .clk_32_768K     (clk_32_768K),
        .rst_n           (rst_n),
        .Number_Data     (Number_Data),
        .Blink           (Blink),
        .Row_Scan_Sig    (Row_Scan_Sig),
        .Column_Scan_Sig (Column_Scan_Sig)
    );

    always #5 clk_32_768K = ~clk_32_768K;

    typedef struct {
        int         cyc;
        logic [7:0] row;
        logic [5:0] col;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   run;

    logic [23:0] m_snap;
    logic [1:0]  m_prev;
    int          m_last_chg;

    // Active-high {g,f,e,d,c,b,a} for 0..9; the model inverts them.
    logic [6:0] seg_hi [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] pat(input logic [3:0] n);
        if (n > 4'd9) return 7'h7F;
        return ~seg_hi[int'(n)];
    endfunction

    // First cycle >= from whose output shows digit idx, six counts into its slot.
    function automatic int next_digit_cyc(input int from, input int idx);
        int c;
        c = from;
        while (!((((c - 1) / SCAN_DIV) % 6 == idx) && ((c - 1) % SCAN_DIV == 5))) c++;
        return c;
    endfunction

    task automatic step();
        int         p;
        int         idx;
        bit         chg;
        bit         dark;
        logic [3:0] nib;
        exp_t       e;
        p   = cyc % SCAN_DIV;
        idx = (cyc / SCAN_DIV) % 6;
        chg = (Blink != m_prev);
        if (chg) m_last_chg = cyc;
        dark = (Blink != 2'b00) && !chg && ((((cyc - m_last_chg - 1) / BLINK_HALF) % 2) == 1);
        e.cyc = cyc + 1;
        e.row = 8'hFF;
        e.col = 6'h3F;
        if (p != SCAN_DIV - 1) begin
            e.col[idx] = 1'b0;
            if (dark && int'(Blink) == idx / 2 + 1) begin
                e.row = 8'hFF;
            end else begin
                nib   = m_snap[idx*4 +: 4];
                e.row = {~DP_MASK[idx], pat(nib)};
`ifdef SEG_LEADING_ZERO_BLANK_EN
                if (idx == 5 && nib == 4'd0) e.row[6:0] = 7'h7F;
`endif
            end
        end
        exp_q.push_back(e);
        if (p == SCAN_DIV - 1 && idx == 5) m_snap = Number_Data;
        m_prev = Blink;
        @(posedge clk_32_768K);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic probe(input string tag, input logic [5:0] col_exp, input logic [7:0] row_exp);
        check_val({tag, "_col"}, {26'h0, Column_Scan_Sig}, {26'h0, col_exp});
        check_val({tag, "_row"}, {24'h0, Row_Scan_Sig}, {24'h0, row_exp});
    endtask

    task automatic do_reset();
        run   = 1'b0;
        rst_n = 1'b0;
        #2;
        probe("rst_async", 6'h3F, 8'hFF);
        repeat (3) @(posedge clk_32_768K);
        #1;
        probe("rst_hold", 6'h3F, 8'hFF);
        exp_q.delete();
        cyc        = 0;
        m_snap     = 24'h0;
        m_prev     = 2'b00;
        m_last_chg = -1;
        rst_n      = 1'b1;
        run        = 1'b1;
    endtask

    always @(negedge clk_32_768K) begin
        if (run && exp_q.size() > 0) begin
            if (exp_q[0].cyc == cyc) begin
                e_mon = exp_q.pop_front();
                check_val("row", {24'h0, Row_Scan_Sig}, {24'h0, e_mon.row});
                check_val("col", {26'h0, Column_Scan_Sig}, {26'h0, e_mon.col});
            end else if (exp_q[0].cyc < cyc) begin
                e_mon = exp_q.pop_front();
                check_val("sb_stale", e_mon.cyc, cyc);
            end
        end
    end

    int c0;
    int c1;
    int t;

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        run      = 1'b0;
        #1;
        @(posedge clk_32_768K);
        #1;
        do_reset();
        Number_Data = 24'h123456;
        step();
        probe("first_slot", 6'b111110, 8'hC0);

        t = next_digit_cyc(FRAME, 0);
        step_to(t);
        probe("d0_six", 6'b111110, 8'h82);
        t = next_digit_cyc(cyc + 1, 2);
        step_to(t);
        probe("d2_four_dp", 6'b111011, 8'h19);
        step_to(t + 26);
        probe("dead", 6'h3F, 8'hFF);
        step_to(next_digit_cyc(cyc + 1, 5));
        probe("d5_one", 6'b011111, 8'hF9);

        // Change input while digit 3 of frame 2 is being scanned.
        step_to(15 * SCAN_DIV + 11);
        Number_Data = 24'h000000;
        step_to(next_digit_cyc(cyc + 1, 4));
        probe("midframe_d4", 6'b101111, 8'h24);
        step_to(next_digit_cyc(cyc + 1, 5));
        probe("midframe_d5", 6'b011111, 8'hF9);
        step_to(next_digit_cyc(cyc + 1, 0));
        probe("newframe_d0", 6'b111110, 8'hC0);

        Number_Data = 24'hAB0000;
        step_to(next_digit_cyc(4 * FRAME, 4));
        probe("hex_d4_blank_dp", 6'b101111, 8'h7F);
        step_to(next_digit_cyc(cyc + 1, 5));
        probe("hex_d5_blank", 6'b011111, 8'hFF);

        Number_Data = 24'h095959;
        step_to(next_digit_cyc(6 * FRAME, 4));
        probe("lz_d4_nine", 6'b101111, 8'h10);
        step_to(next_digit_cyc(cyc + 1, 5));
`ifdef SEG_LEADING_ZERO_BLANK_EN
        probe("lz_d5", 6'b011111, 8'hFF);
`else
        probe("lz_d5", 6'b011111, 8'hC0);
`endif

        Number_Data = 24'h123456;
        Blink       = 2'b10;
        c0 = cyc;
        step_to(next_digit_cyc(c0 + 200, 2));
        probe("blink_vis_d2", 6'b111011, 8'h19);
        step_to(next_digit_cyc(c0 + BLINK_HALF + 2, 2));
        probe("blink_dark_d2", 6'b111011, 8'hFF);
        step_to(next_digit_cyc(cyc + 1, 3));
        probe("blink_dark_d3", 6'b110111, 8'hFF);
        step_to(next_digit_cyc(cyc + 1, 0));
        probe("blink_other_d0", 6'b111110, 8'h82);
        step_to(next_digit_cyc(cyc + 1, 4));
        Blink = 2'b11;
        c1 = cyc;
        step();
        probe("blink_switch_d4", 6'b101111, 8'h24);
        step_to(next_digit_cyc(cyc + 1, 2));
        probe("blink_switch_d2", 6'b111011, 8'h19);
        step_to(next_digit_cyc(c1 + BLINK_HALF + 2, 5));
        probe("blink_hr_dark_d5", 6'b011111, 8'hFF);
        step_to(next_digit_cyc(cyc + 1, 2));
        probe("blink_hr_d2_vis", 6'b111011, 8'h19);
        Blink = 2'b00;
        step_to(next_digit_cyc(cyc + 1, 5));
        probe("blink_off_d5", 6'b011111, 8'hF9);

        // Reset in the middle of a driven slot.
        step_to(next_digit_cyc(cyc + 1, 3) + 4);
        do_reset();
        step();
        probe("rerst_slot0", 6'b111110, 8'hC0);
        step_to(next_digit_cyc(FRAME, 0));
        probe("rerst_fresh_d0", 6'b111110, 8'h82);
        step_to(cyc + 3);

        check_val("sb_drain", exp_q.size() <= 1, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
